// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder: FSM encoding,
// word width and the memory-mapped I/O register addresses.
package lc3_mem_pkg;

   localparam int LC3_WORD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } mem_state_e;

   localparam logic [LC3_WORD_W-1:0] ADDR_KBSR = 16'hFE00;
   localparam logic [LC3_WORD_W-1:0] ADDR_KBDR = 16'hFE02;
   localparam logic [LC3_WORD_W-1:0] ADDR_DSR  = 16'hFE04;
   localparam logic [LC3_WORD_W-1:0] ADDR_DDR  = 16'hFE06;

   function automatic logic is_mmio(input logic [LC3_WORD_W-1:0] a);
      return (a == ADDR_KBSR) || (a == ADDR_KBDR) || (a == ADDR_DSR) || (a == ADDR_DDR);
   endfunction

endpackage

// File: rtl/lc3_mem_array.sv
// Synchronous single-port word RAM, read-first.
module lc3_mem_array
   import lc3_mem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter     INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [LC3_WORD_W-1:0] wdata,
   output logic [LC3_WORD_W-1:0] rdata
);

   logic [LC3_WORD_W-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 MAR/MDR/memWE interface: fixed-latency
// RAM access with a one-cycle memR. Optional keyboard/display MMIO under LC3_MMIO_EN.
module lc3_mem_responder
   import lc3_mem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2,
   parameter     INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [LC3_WORD_W-1:0] busIn,
   input  logic                  ldMAR,
   input  logic                  ldMDR,
   input  logic                  memEN,
   input  logic                  memWE,
   output logic [LC3_WORD_W-1:0] MDROut,
   output logic                  memR,
   output logic                  memBusy,
   output logic                  addrErr
`ifdef LC3_MMIO_EN
   ,
   input  logic [7:0]            kbdData,
   input  logic                  kbdValid,
   output logic [7:0]            dispData,
   output logic                  dispValid,
   input  logic                  dispReady
`endif
);

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   mem_state_e            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [LC3_WORD_W-1:0] mar_q, mar_d;
   logic [LC3_WORD_W-1:0] mdr_q, mdr_d;
   logic [LC3_WORD_W-1:0] acc_addr_q, acc_addr_d;
   logic [LC3_WORD_W-1:0] acc_data_q, acc_data_d;
   logic                  memr_q, memr_d;
   logic                  addr_err_q, addr_err_d;

   logic                  ram_we;
   logic [DEPTH_LOG2-1:0] ram_addr;
   logic [LC3_WORD_W-1:0] ram_rdata;
   logic                  done;
   logic                  oor;

   assign done = (state_q != ST_IDLE) && (cnt_q == 4'd0);
   assign oor  = |(acc_addr_q >> DEPTH_LOG2);

`ifdef LC3_MMIO_EN
   logic                  kbsr_q, kbsr_d;
   logic [7:0]            kbdr_q, kbdr_d;
   logic [7:0]            disp_data_q, disp_data_d;
   logic                  disp_valid_q, disp_valid_d;
   logic [LC3_WORD_W-1:0] mmio_rdata;

   always_comb begin
      mmio_rdata = '0;
      case (acc_addr_q)
         ADDR_KBSR: mmio_rdata = {kbsr_q, 15'd0};
         ADDR_KBDR: mmio_rdata = {8'd0, kbdr_q};
         ADDR_DSR:  mmio_rdata = {dispReady, 15'd0};
         default:   mmio_rdata = '0;
      endcase
   end

   // A completing KBDR read wins over a coincident keyboard strobe (byte dropped).
   always_comb begin
      kbsr_d       = kbsr_q;
      kbdr_d       = kbdr_q;
      disp_data_d  = disp_data_q;
      disp_valid_d = 1'b0;
      if (done && state_q == ST_READ && acc_addr_q == ADDR_KBDR) begin
         kbsr_d = 1'b0;
      end else if (kbdValid && !kbsr_q) begin
         kbsr_d = 1'b1;
         kbdr_d = kbdData;
      end
      if (done && state_q == ST_WRITE && acc_addr_q == ADDR_DDR && dispReady) begin
         disp_data_d  = acc_data_q[7:0];
         disp_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kbsr_q       <= 1'b0;
         kbdr_q       <= '0;
         disp_data_q  <= '0;
         disp_valid_q <= 1'b0;
      end else begin
         kbsr_q       <= kbsr_d;
         kbdr_q       <= kbdr_d;
         disp_data_q  <= disp_data_d;
         disp_valid_q <= disp_valid_d;
      end
   end

   assign dispData  = disp_data_q;
   assign dispValid = disp_valid_q;
`endif

   // Address/data are snapshotted at accept so a same-edge ldMAR/ldMDR only
   // affects the next request. The RAM reads one edge before completion so
   // MDR can capture the data on the memR edge.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mar_d      = mar_q;
      mdr_d      = mdr_q;
      acc_addr_d = acc_addr_q;
      acc_data_d = acc_data_q;
      memr_d     = 1'b0;
      addr_err_d = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = (state_q == ST_IDLE) ? mar_q[DEPTH_LOG2-1:0] : acc_addr_q[DEPTH_LOG2-1:0];
      case (state_q)
         ST_IDLE: begin
            if (ldMAR) mar_d = busIn;
            if (ldMDR) mdr_d = busIn;
            if (memEN) begin
               state_d    = memWE ? ST_WRITE : ST_READ;
               cnt_d      = CNT_INIT;
               acc_addr_d = mar_q;
               acc_data_d = mdr_q;
            end
         end
         default: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = ST_IDLE;
               memr_d  = 1'b1;
`ifdef LC3_MMIO_EN
               if (is_mmio(acc_addr_q)) begin
                  if (state_q == ST_READ) mdr_d = mmio_rdata;
               end else
`endif
               if (oor) begin
                  addr_err_d = 1'b1;
                  if (state_q == ST_READ) mdr_d = '0;
               end else if (state_q == ST_READ) begin
                  mdr_d = ram_rdata;
               end else begin
                  ram_we = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         mar_q      <= '0;
         mdr_q      <= '0;
         acc_addr_q <= '0;
         acc_data_q <= '0;
         memr_q     <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mar_q      <= mar_d;
         mdr_q      <= mdr_d;
         acc_addr_q <= acc_addr_d;
         acc_data_q <= acc_data_d;
         memr_q     <= memr_d;
         addr_err_q <= addr_err_d;
      end
   end

   lc3_mem_array #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .INIT_FILE  (INIT_FILE)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (acc_data_q),
      .rdata (ram_rdata)
   );

   assign MDROut  = mdr_q;
   assign memR    = memr_q;
   assign memBusy = (state_q != ST_IDLE);
   assign addrErr = addr_err_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench: dut0 runs LATENCY=2, dut1 runs LATENCY=1; they share all
// inputs except memEN, so each request targets exactly one instance.
module tb_lc3_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] busIn;
   logic        ldMAR, ldMDR, en0, en1, memWE;
   logic [15:0] mdr0, mdr1;
   logic        memR0, memR1, busy0, busy1, err0, err1;
   int          checks = 0;
   int          errors = 0;
   int          lat;
   int          n;
`ifdef LC3_MMIO_EN
   logic [7:0]  kbdData;
   logic        kbdValid, dispReady;
   logic [7:0]  dispData0, dispData1;
   logic        dispValid0, dispValid1;
`endif

   always #5 clk = ~clk;

   lc3_mem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut0 (
      .clk(clk), .reset(reset), .busIn(busIn), .ldMAR(ldMAR), .ldMDR(ldMDR),
      .memEN(en0), .memWE(memWE), .MDROut(mdr0), .memR(memR0), .memBusy(busy0),
      .addrErr(err0)
`ifdef LC3_MMIO_EN
      , .kbdData(kbdData), .kbdValid(kbdValid), .dispData(dispData0),
      .dispValid(dispValid0), .dispReady(dispReady)
`endif
   );

   lc3_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .busIn(busIn), .ldMAR(ldMAR), .ldMDR(ldMDR),
      .memEN(en1), .memWE(memWE), .MDROut(mdr1), .memR(memR1), .memBusy(busy1),
      .addrErr(err1)
`ifdef LC3_MMIO_EN
      , .kbdData(kbdData), .kbdValid(kbdValid), .dispData(dispData1),
      .dispValid(dispValid1), .dispReady(dispReady)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Optionally loads MAR/MDR, pulses memEN, then returns in the memR cycle
   // with lat = edges from accept to memR (-1 if it never came).
   task automatic req(input bit sel, input bit load, input logic we,
                      input logic [15:0] addr, input logic [15:0] data, output int l);
      if (load) begin
         busIn = addr; ldMAR = 1'b1; step();
         ldMAR = 1'b0; busIn = data; ldMDR = 1'b1; step();
         ldMDR = 1'b0;
      end
      memWE = we;
      if (sel) en1 = 1'b1; else en0 = 1'b1;
      step();
      en0 = 1'b0; en1 = 1'b0; memWE = 1'b0;
      l = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if ((sel ? memR1 : memR0) === 1'b1) begin
            l = i;
            break;
         end
      end
   endtask

   initial begin
      reset = 1'b0; busIn = '0; ldMAR = 0; ldMDR = 0; en0 = 0; en1 = 0; memWE = 0;
`ifdef LC3_MMIO_EN
      kbdData = '0; kbdValid = 0; dispReady = 0;
`endif
      step(); step();
      chk("rst_mdr", mdr0, 16'h0000);
      chk("rst_memr", {15'd0, memR0}, 16'd0);
      chk("rst_busy", {15'd0, busy0}, 16'd0);
      chk("rst_err", {15'd0, err0}, 16'd0);
      chk("rst_mdr1", mdr1, 16'h0000);
`ifdef LC3_MMIO_EN
      chk("rst_dvalid", {15'd0, dispValid0}, 16'd0);
      chk("rst_ddata", {8'd0, dispData0}, 16'd0);
`endif
      reset = 1'b1;
      step();

      // write then read at LATENCY=2
      req(0, 1, 1'b1, 16'h0001, 16'h1234, lat);
      chk("t1_wr_lat", 16'(lat), 16'd2);
      chk("t1_wr_err", {15'd0, err0}, 16'd0);
      req(0, 1, 1'b0, 16'h0001, 16'h0000, lat);
      chk("t1_rd_lat", 16'(lat), 16'd2);
      chk("t1_rd_data", mdr0, 16'h1234);
      step();
      chk("t1_memr_pulse", {15'd0, memR0}, 16'd0);

      // memEN and ldMAR during READ are ignored
      busIn = 16'h0001; ldMAR = 1; step(); ldMAR = 0;
      memWE = 0; en0 = 1; step();
      en0 = 0;
      chk("t2_busy_k", {15'd0, busy0}, 16'd1);
      en0 = 1; busIn = 16'h0400; ldMAR = 1; step();
      en0 = 0; ldMAR = 0;
      chk("t2_memr_k1", {15'd0, memR0}, 16'd0);
      chk("t2_busy_k1", {15'd0, busy0}, 16'd1);
      step();
      chk("t2_memr_k2", {15'd0, memR0}, 16'd1);
      chk("t2_busy_drop", {15'd0, busy0}, 16'd0);
      chk("t2_data", mdr0, 16'h1234);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (memR0 === 1'b1) n++;
      end
      chk("t2_extra_memr", 16'(n), 16'd0);
      req(0, 0, 1'b0, 16'h0000, 16'h0000, lat);
      chk("t2_mar_kept", mdr0, 16'h1234);
      chk("t2_mar_err", {15'd0, err0}, 16'd0);

      // out of range
      req(0, 1, 1'b1, 16'h0000, 16'h5555, lat);
      chk("t3_wr0_err", {15'd0, err0}, 16'd0);
      req(0, 1, 1'b0, 16'h0400, 16'hFFFF, lat);
      chk("t3_oor_rd_lat", 16'(lat), 16'd2);
      chk("t3_oor_rd_data", mdr0, 16'h0000);
      chk("t3_oor_rd_err", {15'd0, err0}, 16'd1);
      step();
      chk("t3_err_pulse", {15'd0, err0}, 16'd0);
      req(0, 1, 1'b1, 16'h0400, 16'hAAAA, lat);
      chk("t3_oor_wr_err", {15'd0, err0}, 16'd1);
      req(0, 1, 1'b0, 16'h0000, 16'h0000, lat);
      chk("t3_no_alias", mdr0, 16'h5555);
      chk("t3_in_range_err", {15'd0, err0}, 16'd0);

      // reset during WRITE abandons the access
      req(0, 1, 1'b1, 16'h0005, 16'hBEEF, lat);
      busIn = 16'h0005; ldMAR = 1; step();
      ldMAR = 0; busIn = 16'h0000; ldMDR = 1; step();
      ldMDR = 0; memWE = 1; en0 = 1; step();
      en0 = 0; memWE = 0;
      chk("t4_busy", {15'd0, busy0}, 16'd1);
      reset = 1'b0;
      #1;
      chk("t4_rst_mdr", mdr0, 16'h0000);
      chk("t4_rst_busy", {15'd0, busy0}, 16'd0);
      step();
      reset = 1'b1;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         if (memR0 === 1'b1) n++;
         step();
      end
      chk("t4_no_memr", 16'(n), 16'd0);
      req(0, 0, 1'b0, 16'h0000, 16'h0000, lat);
      chk("t4_mar_zero", mdr0, 16'h5555);
      req(0, 1, 1'b0, 16'h0005, 16'h0000, lat);
      chk("t4_ram_kept", mdr0, 16'hBEEF);

      // LATENCY=1 back-to-back reads
      req(1, 1, 1'b1, 16'h0002, 16'h0A0A, lat);
      chk("t5_wr_lat", 16'(lat), 16'd1);
      req(1, 1, 1'b1, 16'h0003, 16'h0B0B, lat);
      step();
      busIn = 16'h0002; ldMAR = 1; step();
      busIn = 16'h0003; memWE = 0; en1 = 1; step();
      ldMAR = 0; en1 = 0;
      chk("t5_memr_k", {15'd0, memR1}, 16'd0);
      chk("t5_busy_k", {15'd0, busy1}, 16'd1);
      step();
      chk("t5_memr_a", {15'd0, memR1}, 16'd1);
      chk("t5_data_a", mdr1, 16'h0A0A);
      en1 = 1; step();
      en1 = 0;
      chk("t5_gap", {15'd0, memR1}, 16'd0);
      chk("t5_busy_b", {15'd0, busy1}, 16'd1);
      step();
      chk("t5_memr_b", {15'd0, memR1}, 16'd1);
      chk("t5_data_b", mdr1, 16'h0B0B);
      step();
      chk("t5_memr_end", {15'd0, memR1}, 16'd0);

`ifdef LC3_MMIO_EN
      // keyboard / display registers
      kbdData = 8'h41; kbdValid = 1; step();
      kbdValid = 0; kbdData = 8'h00;
      req(0, 1, 1'b0, 16'hFE00, 16'h0000, lat);
      chk("t6_kbsr_lat", 16'(lat), 16'd2);
      chk("t6_kbsr_set", mdr0, 16'h8000);
      chk("t6_kbsr_err", {15'd0, err0}, 16'd0);
      req(0, 1, 1'b0, 16'hFE02, 16'h0000, lat);
      chk("t6_kbdr", mdr0, 16'h0041);
      req(0, 1, 1'b0, 16'hFE00, 16'h0000, lat);
      chk("t6_kbsr_clr", mdr0, 16'h0000);
      dispReady = 1;
      req(0, 1, 1'b0, 16'hFE04, 16'h0000, lat);
      chk("t6_dsr", mdr0, 16'h8000);
      req(0, 1, 1'b1, 16'hFE06, 16'h0048, lat);
      chk("t6_ddr_lat", 16'(lat), 16'd2);
      chk("t6_dvalid", {15'd0, dispValid0}, 16'd1);
      chk("t6_ddata", {8'd0, dispData0}, 16'h0048);
      step();
      chk("t6_dvalid_pulse", {15'd0, dispValid0}, 16'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
